tff_toggle_arbiter: RTL and testbench
=====================================

Name: tff_toggle_arbiter

Overview:
- Shared bank of WIDTH toggle (T-type) bits, owned by one block and driven by NREQ requesters.
- Each requester submits a toggle mask. A round-robin arbiter grants one requester per cycle, and the bank updates as q <= q ^ mask.
- An optional lock gives one requester exclusive multi-cycle access, released explicitly or by idle timeout.
- Sits between the control agents and any logic that reads the toggle state.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of toggle bits in the bank
- LOCK_MAX, 16, consecutive idle owner cycles before a forced lock release (>=1)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_lock  in  NREQ  per-requester: keep the grant after this transfer
- req_mask  in  NREQ*WIDTH  toggle masks; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot or zero grant (combinational)
- clr  in  1  synchronous clear of the bank
- q  out  WIDTH  toggle bank state (registered)
- last_id  out  clog2(NREQ)  index of the most recent transfer (registered)
- last_valid  out  1  one-cycle pulse, the cycle after each transfer
- locked  out  1  high while the FSM is in LOCKED (registered)

Behaviour:
- Reset (synchronous) sets: q=0, last_id=0, last_valid=0, locked=0, rr_ptr=0, FSM=IDLE, idle_cnt=0. reset has priority over every other input.
- Transfer definition: a transfer occurs on cycle t when req_valid[i] && req_ready[i].
  - At edge t+1: q <= q ^ mask_i, last_id <= i, last_valid <= 1.
  - Latency is one cycle.
- FSM state IDLE (arbitration):
  - Grant the first valid requester searching from rr_ptr upward, modulo NREQ.
  - rr_ptr <= granted index + 1 (wrapping).
  - If the granted requester has req_lock=1, go to LOCKED, owner <= i, idle_cnt <= 0.
- FSM state LOCKED:
  - Only the owner can receive req_ready, and it is granted whenever its req_valid is high.
  - All other requesters see ready=0.
  - Owner transfer with req_lock=0: return to IDLE, rr_ptr <= owner + 1.
  - Owner transfer with req_lock=1: stay in LOCKED, idle_cnt <= 0.
  - Owner req_valid=0: idle_cnt increments.
  - When idle_cnt reaches LOCK_MAX-1 with the owner still invalid: force IDLE on the next edge, rr_ptr <= owner + 1.
- locked mirrors the state register: it is 1 exactly while the FSM is in LOCKED.
- clr:
  - All req_ready are forced to 0 that cycle, so no transfer occurs.
  - q <= 0. FSM, rr_ptr and idle_cnt are unchanged.
  - In LOCKED, a clr cycle counts as an idle cycle only if the owner's valid is low.
- Handshake rules:
  - A requester may hold valid and change its mask freely until a transfer occurs.
  - Masks are sampled only on the transfer cycle.
  - req_lock is ignored unless the transfer occurs.
- Zero mask: a legal transfer; q is unchanged, last_valid still pulses.
- No valid requesters: req_ready=0, last_valid=0 next cycle, q holds.
- Reset asserted mid-lock: full reset; the next arbitration starts from requester 0.

Decomposition:
- Package tff_arb_pkg holds:
  - default NREQ, WIDTH and LOCK_MAX constants
  - FSM state encoding (IDLE=0, LOCKED=1)
  - clog2-based width constant for IDX_W
- Sub-module rr_arbiter (combinational priority search from a pointer):
  - inputs req[NREQ], ptr
  - outputs grant one-hot, grant_idx, any
- The top level contains the FSM, idle counter, bank register and output registers.

Test Plan (NREQ=4, WIDTH=8, LOCK_MAX=16):
1. reset, then req0 valid, mask 0x0F, lock 0 -> ready=4'b0001. Next cycle: q=0x0F, last_id=0, last_valid=1. One cycle later: last_valid=0.
2. All four valid continuously, masks 0x01/0x02/0x04/0x08 -> grant order 0,1,2,3,0. After 4 transfers q=0x0F; after 8 transfers q=0x00.
3. req1 valid alone, mask 0xA5, for 2 cycles -> q: 0xA5 then 0x00. last_id=1 both cycles.
4. All valid; req2 lock=1, mask 0x80 on its first grant -> locked=1 and only req2 ready for 3 transfers (q toggles bit7 each). Final req2 transfer with lock=0 -> locked=0, next grant goes to req3.
5. req2 locks, then drops valid while req0 stays valid -> req0 ready=0 for 16 cycles. locked falls after the 16th idle cycle, then req0 is granted (rr_ptr=3 wraps past 3 since req3 is idle).
6. q=0x3C and clr=1 with req0 valid -> ready=0, next cycle q=0x00, no last_valid pulse. Then assert reset during LOCKED -> q=0, locked=0, and the next grant searches from index 0.

Source files
------------

// File: rtl/tff_arb_pkg.sv
// Shared constants, FSM encoding and index-width helper for the toggle-bank arbiter.
package tff_arb_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int WIDTH_DEF    = 8;
    localparam int LOCK_MAX_DEF = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // At least one bit so single-value ranges still get a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_w(NREQ_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after ptr_i, wrapping.
module rr_arbiter
    import tff_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]          req_i,
    input  logic [idx_w(NREQ)-1:0]   ptr_i,
    output logic [NREQ-1:0]          grant_o,
    output logic [idx_w(NREQ)-1:0]   grant_idx_o,
    output logic                     any_o
);

    localparam int IW = idx_w(NREQ);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o = idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Shared T-bit bank: one granted requester per cycle XORs its mask into q,
// with an optional multi-cycle lock released explicitly or by idle timeout.
module tff_toggle_arbiter
    import tff_arb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_lock,
    input  logic [NREQ*WIDTH-1:0]     req_mask,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      clr,
    output logic [WIDTH-1:0]          q,
    output logic [idx_w(NREQ)-1:0]    last_id,
    output logic                      last_valid,
    output logic                      locked
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = idx_w(LOCK_MAX);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_id_q, last_id_d;
    logic [CW-1:0]     idle_cnt_q, idle_cnt_d;
    logic [WIDTH-1:0]  bank_q, bank_d;
    logic              last_valid_q, last_valid_d;

    logic [NREQ-1:0]   arb_grant;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    logic              grant_ok;
    logic              xfer;
    logic [IW-1:0]     xfer_idx;
    logic [WIDTH-1:0]  xfer_mask;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    // Handshake: a transfer happens in a cycle where req_valid[i] && req_ready[i];
    // ready is combinational, at most one-hot, and is withheld on clr or reset.
    always_comb begin
        req_ready = '0;
        grant_ok  = !reset && !clr;
        xfer_idx  = (state_q == ST_IDLE) ? arb_idx : owner_q;
        if (state_q == ST_IDLE) begin
            xfer = grant_ok && arb_any;
            if (grant_ok) req_ready = arb_grant;
        end else begin
            xfer = grant_ok && req_valid[owner_q];
            req_ready[owner_q] = xfer;
        end
        xfer_mask = req_mask[int'(xfer_idx)*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        idle_cnt_d   = idle_cnt_q;
        bank_d       = clr ? '0 : bank_q;
        last_id_d    = last_id_q;
        last_valid_d = xfer;
        if (xfer) begin
            bank_d    = bank_q ^ xfer_mask;
            last_id_d = xfer_idx;
        end
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    rr_ptr_d = wrap_inc(xfer_idx);
                    if (req_lock[xfer_idx]) begin
                        state_d    = ST_LOCKED;
                        owner_d    = xfer_idx;
                        idle_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    if (req_lock[owner_q]) begin
                        idle_cnt_d = '0;
                    end else begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = wrap_inc(owner_q);
                    end
                end else if (!req_valid[owner_q]) begin
                    // A clr cycle with the owner still valid is not idle time.
                    if (idle_cnt_q == CW'(LOCK_MAX - 1)) begin
                        state_d    = ST_IDLE;
                        rr_ptr_d   = wrap_inc(owner_q);
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            idle_cnt_q   <= '0;
            bank_q       <= '0;
            last_id_q    <= '0;
            last_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            idle_cnt_q   <= idle_cnt_d;
            bank_q       <= bank_d;
            last_id_q    <= last_id_d;
            last_valid_q <= last_valid_d;
        end
    end

    assign q          = bank_q;
    assign last_id    = last_id_q;
    assign last_valid = last_valid_q;
    assign locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Bench for tff_toggle_arbiter: directed scenarios plus random traffic against a
// behavioural model; transfers are scored through an expected queue.
module tb_tff_toggle_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int LOCK_MAX = 16;
    localparam int IW       = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    clr;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_lock;
    logic [NREQ*WIDTH-1:0]   req_mask;
    logic [NREQ-1:0]         req_ready;
    logic [WIDTH-1:0]        q;
    logic [IW-1:0]           last_id;
    logic                    last_valid;
    logic                    locked;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [IW+WIDTH-1:0] exp_q[$];

    // Reference model: bank value, next search start, lock owner (-1 = none), idle cycles.
    int m_q     = 0;
    int m_rr    = 0;
    int m_owner = -1;
    int m_idle  = 0;

    tff_toggle_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .req_mask   (req_mask),
        .req_ready  (req_ready),
        .clr        (clr),
        .q          (q),
        .last_id    (last_id),
        .last_valid (last_valid),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mk(input logic [7:0] m0, m1, m2, m3);
        return {m3, m2, m1, m0};
    endfunction

    function automatic int model_grant(input logic [NREQ-1:0] v, input logic c, input logic r);
        if (r || c) return -1;
        if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock cycle: drive at negedge, check combinational/registered outputs, advance model.
    task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                         input logic [NREQ*WIDTH-1:0] m, input logic c, input logic r);
        int               g;
        logic [WIDTH-1:0] mg;
        logic [NREQ-1:0]  exp_ready;
        @(negedge clk);
        req_valid = v;
        req_lock  = l;
        req_mask  = m;
        clr       = c;
        reset     = r;
        #1;
        g = model_grant(v, c, r);
        exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("q", 32'(q), 32'(m_q));
        check("locked", 32'(locked), 32'(m_owner >= 0));
        if (r) begin
            m_q = 0; m_rr = 0; m_owner = -1; m_idle = 0;
        end else begin
            if (c) m_q = 0;
            if (g >= 0) begin
                mg  = m[g*WIDTH +: WIDTH];
                m_q = m_q ^ int'(mg);
                exp_q.push_back({IW'(g), WIDTH'(m_q)});
                if (m_owner < 0) begin
                    m_rr = (g + 1) % NREQ;
                    if (l[g]) begin m_owner = g; m_idle = 0; end
                end else if (l[g]) begin
                    m_idle = 0;
                end else begin
                    m_rr = (g + 1) % NREQ; m_owner = -1;
                end
            end else if (m_owner >= 0 && !v[m_owner]) begin
                if (m_idle == LOCK_MAX - 1) begin
                    m_rr = (m_owner + 1) % NREQ; m_owner = -1; m_idle = 0;
                end else begin
                    m_idle++;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        logic [IW+WIDTH-1:0] e;
        #1;
        if (last_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL pulse: last_valid high with last_id=%0d q=0x%0h, expected no transfer", last_id, q);
            end else begin
                e = exp_q.pop_front();
                check("xfer_last_id", 32'(last_id), 32'(e[IW+WIDTH-1:WIDTH]));
                check("xfer_q", 32'(q), 32'(e[WIDTH-1:0]));
            end
        end
    end

    initial begin
        logic [NREQ-1:0] rv, rl;
        logic [31:0]     rm, m4;
        logic            rc, rrst;
        reset = 1'b1; clr = 1'b0; req_valid = '0; req_lock = '0; req_mask = '0;
        repeat (2) @(negedge clk);

        cycle(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b1);
        check("rst_last_id", 32'(last_id), 32'h0);
        check("rst_last_valid", 32'(last_valid), 32'h0);

        // Single requester, one-cycle latency and single pulse.
        cycle(4'b0001, 4'b0000, mk(8'h0F, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
        check("t1_ready", 32'(req_ready), 32'h1);
        cycle(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0);
        check("t1_q", 32'(q), 32'h0F);
        check("t1_last_id", 32'(last_id), 32'h0);
        check("t1_last_valid", 32'(last_valid), 32'h1);
        cycle(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0);
        check("t1_pulse_end", 32'(last_valid), 32'h0);

        // Round-robin rotation with all requesters valid.
        cycle(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cycle(4'b1111, 4'b0000, mk(8'h01, 8'h02, 8'h04, 8'h08), 1'b0, 1'b0);
            check("t2_grant_order", 32'(req_ready), 32'(1 << (k % 4)));
            if (k == 4) check("t2_q_half", 32'(q), 32'h0F);
        end
        cycle(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0);
        check("t2_q_full", 32'(q), 32'h00);

        // Repeated transfers from one requester.
        cycle(4'b0010, 4'b0000, mk(8'h00, 8'hA5, 8'h00, 8'h00), 1'b0, 1'b0);
        cycle(4'b0010, 4'b0000, mk(8'h00, 8'hA5, 8'h00, 8'h00), 1'b0, 1'b0);
        check("t3_q1", 32'(q), 32'hA5);
        check("t3_id1", 32'(last_id), 32'h1);
        cycle(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0);
        check("t3_q2", 32'(q), 32'h00);
        check("t3_id2", 32'(last_id), 32'h1);

        // Lock by requester 2, explicit release, then rotation resumes at 3.
        m4 = mk(8'h01, 8'h02, 8'h80, 8'h08);
        cycle(4'b1111, 4'b0100, m4, 1'b0, 1'b0);
        check("t4_first_grant", 32'(req_ready), 32'h4);
        repeat (2) begin
            cycle(4'b1111, 4'b0100, m4, 1'b0, 1'b0);
            check("t4_owner_only", 32'(req_ready), 32'h4);
            check("t4_locked", 32'(locked), 32'h1);
        end
        cycle(4'b1111, 4'b0000, m4, 1'b0, 1'b0);
        check("t4_release_grant", 32'(req_ready), 32'h4);
        cycle(4'b1111, 4'b0000, m4, 1'b0, 1'b0);
        check("t4_next_grant", 32'(req_ready), 32'h8);
        check("t4_unlocked", 32'(locked), 32'h0);
        check("t4_q", 32'(q), 32'h00);

        // Idle-timeout release.
        cycle(4'b0100, 4'b0100, m4, 1'b0, 1'b0);
        for (int i = 0; i < LOCK_MAX; i++) begin
            cycle(4'b0001, 4'b0000, m4, 1'b0, 1'b0);
            check("t5_req0_blocked", 32'(req_ready), 32'h0);
        end
        cycle(4'b0001, 4'b0000, m4, 1'b0, 1'b0);
        check("t5_req0_granted", 32'(req_ready), 32'h1);
        check("t5_unlocked", 32'(locked), 32'h0);

        // Clear blocks grants; reset mid-lock restarts arbitration at 0.
        cycle(4'b0000, 4'b0000, 32'h0, 1'b1, 1'b0);
        cycle(4'b0001, 4'b0000, mk(8'h3C, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
        cycle(4'b0001, 4'b0000, mk(8'h3C, 8'h00, 8'h00, 8'h00), 1'b1, 1'b0);
        check("t6_q_before_clr", 32'(q), 32'h3C);
        check("t6_clr_ready", 32'(req_ready), 32'h0);
        cycle(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0);
        check("t6_q_cleared", 32'(q), 32'h00);
        check("t6_no_pulse", 32'(last_valid), 32'h0);
        cycle(4'b0010, 4'b0010, mk(8'h11, 8'h22, 8'h33, 8'h44), 1'b0, 1'b0);
        cycle(4'b1111, 4'b0010, mk(8'h11, 8'h22, 8'h33, 8'h44), 1'b0, 1'b0);
        check("t6_locked", 32'(locked), 32'h1);
        cycle(4'b1111, 4'b1111, mk(8'h11, 8'h22, 8'h33, 8'h44), 1'b0, 1'b1);
        cycle(4'b1111, 4'b0000, mk(8'h11, 8'h22, 8'h33, 8'h44), 1'b0, 1'b0);
        check("t6_post_reset_grant", 32'(req_ready), 32'h1);
        check("t6_post_reset_locked", 32'(locked), 32'h0);
        check("t6_post_reset_q", 32'(q), 32'h00);

        // Random traffic: dense, sparse (exercises idle timeout), dense again.
        for (int p = 0; p < 3; p++) begin
            for (int n = 0; n < 300; n++) begin
                for (int b = 0; b < NREQ; b++) begin
                    rv[b] = (p == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
                    rl[b] = ($urandom_range(0, 3) == 0);
                end
                rm   = $urandom;
                rc   = ($urandom_range(0, 15) == 0);
                rrst = ($urandom_range(0, 63) == 0);
                cycle(rv, rl, rm, rc, rrst);
            end
        end

        cycle(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0);
        cycle(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
